// File: rtl/wombat_command_issuer.sv
// rtl/wombat_command_issuer.sv - host-side request-to-frame issuer for the wombat register protocol
module wombat_command_issuer #(
    parameter int                    WORD_WIDTH     = 8,
    parameter int                    REG_WIDTH      = 4,
    parameter bit                    LITTLE_ENDIAN  = 1'b0,
    parameter int                    TIMEOUT_CYCLES = 1_000_000,
    parameter logic [WORD_WIDTH-1:0] OP_WRITE       = 8'h57,
    parameter logic [WORD_WIDTH-1:0] OP_READ        = 8'h52
) (
    input  logic                             clk,
    input  logic                             i_reset,
    input  logic                             i_cmd_valid,
    output logic                             o_cmd_ready,
    input  logic                             i_cmd_write,
    input  logic [WORD_WIDTH-1:0]            i_cmd_addr,
    input  logic [WORD_WIDTH*REG_WIDTH-1:0]  i_cmd_value,
    output logic [WORD_WIDTH-1:0]            o_tx_data,
    output logic                             o_tx_valid,
    input  logic                             i_tx_ready,
    input  logic [WORD_WIDTH-1:0]            i_rx_data,
    input  logic                             i_rx_valid,
    output logic                             o_wr_done,
    output logic                             o_rsp_valid,
    output logic [WORD_WIDTH*REG_WIDTH-1:0]  o_rsp_value,
    output logic                             o_rsp_error
);
    localparam int VW = WORD_WIDTH * REG_WIDTH;
    localparam int IW = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST  = IW'(REG_WIDTH - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEND_OP, SEND_ADDR, SEND_DATA, WAIT_RSP} state_t;

    state_t                state, state_next;
    logic                  is_write;
    logic [WORD_WIDTH-1:0] addr;
    logic [VW-1:0]         value;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         widx;
    logic [TW-1:0]         tcnt;
    logic [VW-1:0]         shadow, shadow_next;
    logic                  wr_done, rsp_valid, rsp_error;
    logic [VW-1:0]         rsp_value;

    // Word position of the k-th byte on the wire, shared by send and receive paths.
    assign widx = LITTLE_ENDIAN ? idx : LAST - idx;

    always_comb begin
        shadow_next = shadow;
        shadow_next[widx*WORD_WIDTH +: WORD_WIDTH] = i_rx_data;
    end

    always_comb begin
        state_next  = state;
        o_cmd_ready = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;
        case (state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) state_next = SEND_OP;
            end
            SEND_OP: begin
                o_tx_valid = 1'b1;
                o_tx_data  = is_write ? OP_WRITE : OP_READ;
                if (i_tx_ready) state_next = SEND_ADDR;
            end
            SEND_ADDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = addr;
                if (i_tx_ready) state_next = is_write ? SEND_DATA : WAIT_RSP;
            end
            SEND_DATA: begin
                o_tx_valid = 1'b1;
                o_tx_data  = value[widx*WORD_WIDTH +: WORD_WIDTH];
                if (i_tx_ready && idx == LAST) state_next = IDLE;
            end
            WAIT_RSP: begin
                if (i_rx_valid) begin
                    if (idx == LAST) state_next = IDLE;
                end else if (tcnt == TLAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            addr      <= '0;
            value     <= '0;
            idx       <= '0;
            tcnt      <= '0;
            shadow    <= '0;
            wr_done   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_value <= '0;
        end else begin
            state     <= state_next;
            wr_done   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        is_write <= i_cmd_write;
                        addr     <= i_cmd_addr;
                        value    <= i_cmd_value;
                        idx      <= '0;
                        tcnt     <= '0;
                        shadow   <= '0;
                    end
                end
                SEND_DATA: begin
                    if (i_tx_ready) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST) wr_done <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    // A byte on the expiry cycle still counts, so it is tested first.
                    if (i_rx_valid) begin
                        shadow <= shadow_next;
                        tcnt   <= '0;
                        idx    <= idx + 1'b1;
                        if (idx == LAST) begin
                            rsp_valid <= 1'b1;
                            rsp_value <= shadow_next;
                        end
                    end else if (tcnt == TLAST) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_value <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_wr_done   = wr_done;
    assign o_rsp_valid = rsp_valid;
    assign o_rsp_error = rsp_error;
    assign o_rsp_value = rsp_value;
endmodule

// File: tb/tb_wombat_command_issuer.sv
// tb/tb_wombat_command_issuer.sv - directed table-driven bench for wombat_command_issuer
module tb_wombat_command_issuer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_write, tx_ready, rx_valid;
    logic [7:0]  cmd_addr, rx_data;
    logic [31:0] cmd_value;

    logic        b_cmd_ready, b_tx_valid, b_wr_done, b_rsp_valid, b_rsp_error;
    logic [7:0]  b_tx_data;
    logic [31:0] b_rsp_value;
    logic        l_cmd_ready, l_tx_valid, l_wr_done, l_rsp_valid, l_rsp_error;
    logic [7:0]  l_tx_data;
    logic [31:0] l_rsp_value;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] prev_b = '0;
    logic [31:0] prev_l = '0;

    always #5 clk = ~clk;

    wombat_command_issuer #(.LITTLE_ENDIAN(1'b0), .TIMEOUT_CYCLES(16)) dut_be (
        .clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(b_cmd_ready),
        .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_value(cmd_value),
        .o_tx_data(b_tx_data), .o_tx_valid(b_tx_valid), .i_tx_ready(tx_ready),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_wr_done(b_wr_done),
        .o_rsp_valid(b_rsp_valid), .o_rsp_value(b_rsp_value), .o_rsp_error(b_rsp_error)
    );

    wombat_command_issuer #(.LITTLE_ENDIAN(1'b1), .TIMEOUT_CYCLES(16)) dut_le (
        .clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(l_cmd_ready),
        .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_value(cmd_value),
        .o_tx_data(l_tx_data), .o_tx_valid(l_tx_valid), .i_tx_ready(tx_ready),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_wr_done(l_wr_done),
        .o_rsp_valid(l_rsp_valid), .o_rsp_value(l_rsp_value), .o_rsp_error(l_rsp_error)
    );

    typedef struct {
        bit          wr;
        bit          stall;
        logic [7:0]  addr;
        logic [31:0] value;
        logic [31:0] reply;
        int          nrep;
        logic [47:0] exp_tx;
        logic [47:0] exp_le;
        int          ntx;
        logic [31:0] exp_rsp;
        logic [31:0] exp_rsp_le;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", {31'd0, b_cmd_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, b_tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, b_tx_data}, 32'd0);
        check("rst_wr_done", {31'd0, b_wr_done}, 32'd0);
        check("rst_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
        check("rst_rsp_value", b_rsp_value, 32'd0);
        check("rst_rsp_error", {31'd0, b_rsp_error}, 32'd0);
        check("rst_le_ready", {31'd0, l_cmd_ready}, 32'd1);
        check("rst_le_value", l_rsp_value, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        prev_b = '0;
        prev_l = '0;
    endtask

    task automatic run_txn(input vec_t t);
        logic [7:0] bb [6];
        logic [7:0] lb [6];
        logic [7:0] hold;
        int  nb = 0;
        int  done_cyc = -1;
        bit  stalled = 0;
        @(negedge clk);
        check("cmd_ready_idle", {31'd0, b_cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = t.wr; cmd_addr = t.addr; cmd_value = t.value;
        hold = '0;
        for (int cyc = 1; cyc <= 120 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            rx_valid  = 1'b0;
            if (b_wr_done || b_rsp_valid) begin
                done_cyc = cyc;
                if (t.wr) begin
                    check("wr_done", {31'd0, b_wr_done}, 32'd1);
                    check("wr_no_rsp", {31'd0, b_rsp_valid}, 32'd0);
                    check("wr_ready_same", {31'd0, b_cmd_ready}, 32'd1);
                    check("le_wr_done", {31'd0, l_wr_done}, 32'd1);
                end else begin
                    check("rd_no_wr_done", {31'd0, b_wr_done}, 32'd0);
                    check("rsp_error", {31'd0, b_rsp_error}, {31'd0, t.exp_err});
                    check("rsp_value", b_rsp_value, t.exp_rsp);
                    check("le_rsp_valid", {31'd0, l_rsp_valid}, 32'd1);
                    check("le_rsp_error", {31'd0, l_rsp_error}, {31'd0, t.exp_err});
                    check("le_rsp_value", l_rsp_value, t.exp_rsp_le);
                    prev_b = t.exp_rsp;
                    prev_l = t.exp_rsp_le;
                end
            end else begin
                check("rsp_value_held", b_rsp_value, prev_b);
                check("rsp_error_idle", {31'd0, b_rsp_error}, 32'd0);
            end
            if (stalled) check("tx_data_stable", {24'd0, b_tx_data}, {24'd0, hold});
            tx_ready = t.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_tx_valid && tx_ready) begin
                if (nb < 6) begin
                    bb[nb] = b_tx_data;
                    lb[nb] = l_tx_data;
                end
                nb++;
            end
            stalled = b_tx_valid && !tx_ready;
            hold = b_tx_data;
            if (!t.wr) begin
                if (cyc == 1 || cyc == 2) begin
                    rx_valid = 1'b1;
                    rx_data  = 8'hEE;
                end
                for (int k = 0; k < t.nrep; k++) begin
                    if (cyc == 5 + 10 * k) begin
                        rx_valid = 1'b1;
                        rx_data  = t.reply[31 - 8*k -: 8];
                    end
                end
            end
        end
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
        check("tx_count", nb, t.ntx);
        for (int i = 0; i < t.ntx && i < nb; i++) begin
            check("tx_byte", {24'd0, bb[i]}, {24'd0, t.exp_tx[47 - 8*i -: 8]});
            check("le_tx_byte", {24'd0, lb[i]}, {24'd0, t.exp_le[47 - 8*i -: 8]});
        end
        if (t.exp_lat > 0) check("latency", done_cyc, t.exp_lat);
        @(negedge clk);
        check("single_pulse", {30'd0, b_wr_done, b_rsp_valid}, 32'd0);
        check("ready_after", {31'd0, b_cmd_ready}, 32'd1);
    endtask

    initial begin
        tbl[0] = '{1, 0, 8'h03, 32'hDEADBEEF, 32'h0, 0, 48'h5703DEADBEEF, 48'h5703EFBEADDE, 6,
                   32'h0, 32'h0, 0, 7};
        tbl[1] = '{1, 0, 8'hFF, 32'h00000001, 32'h0, 0, 48'h57FF00000001, 48'h57FF01000000, 6,
                   32'h0, 32'h0, 0, 7};
        tbl[2] = '{1, 1, 8'h03, 32'hDEADBEEF, 32'h0, 0, 48'h5703DEADBEEF, 48'h5703EFBEADDE, 6,
                   32'h0, 32'h0, 0, 0};
        tbl[3] = '{0, 0, 8'h0A, 32'h0, 32'h12345678, 4, 48'h520A00000000, 48'h520A00000000, 2,
                   32'h12345678, 32'h78563412, 0, 36};
        tbl[4] = '{0, 0, 8'h80, 32'h0, 32'hA55A0FF0, 4, 48'h528000000000, 48'h528000000000, 2,
                   32'hA55A0FF0, 32'hF00F5AA5, 0, 36};
        tbl[5] = '{0, 0, 8'h22, 32'h0, 32'hABCD0000, 2, 48'h522200000000, 48'h522200000000, 2,
                   32'h0, 32'h0, 1, 32};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_value = '0;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44; cmd_value = 32'h01020304;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_tx_idle", {30'd0, b_tx_valid, b_wr_done}, 32'd0);
        end
        run_txn(tbl[0]);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h77;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_rst_no_rsp", {30'd0, b_rsp_valid, b_rsp_error}, 32'd0);
        end
        run_txn(tbl[3]);

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stray_ready", {31'd0, b_cmd_ready}, 32'd1);
            check("stray_quiet", {30'd0, b_tx_valid, b_rsp_valid}, 32'd0);
            rx_valid = 1'b1; rx_data = 8'h99;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check("stray_value_held", b_rsp_value, prev_b);
        run_txn(tbl[4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
